// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single SDRAM controller command port between the C64 bus,
// the SPI/ioctl upload path and a periodic refresh scheduler with debt tracking.
module sdram_port_arbiter #(
  parameter int ADDR_W         = 25,
  parameter int REFRESH_CYCLES = 250,
  parameter int URGENT_DEBT    = 2
) (
  input  logic              clk_c64,
  input  logic              reset_n,
  input  logic              c64_req,
  input  logic              c64_we,
  input  logic [ADDR_W-1:0] c64_addr,
  input  logic [7:0]        c64_din,
  output logic [7:0]        c64_dout,
  output logic              c64_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [7:0]        io_din,
  output logic [7:0]        io_dout,
  output logic              io_ack,
  output logic              mem_start,
  output logic              mem_rfsh,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_done,
  output logic [1:0]        grant,
  output logic [1:0]        rfsh_debt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_C64  = 2'd1;
  localparam logic [1:0] GNT_IO   = 2'd2;
  localparam logic [1:0] GNT_RFSH = 2'd3;

  localparam int              CNT_W    = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        debt_q, debt_d;
  logic [1:0]        grant_q, grant_d;
  logic              mem_start_q, mem_start_d;
  logic              mem_rfsh_q, mem_rfsh_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [7:0]        c64_dout_q, c64_dout_d;
  logic [7:0]        io_dout_q, io_dout_d;
  logic              c64_ack_q, c64_ack_d;
  logic              io_ack_q, io_ack_d;

  logic [1:0] winner;
  logic       wrap;
  logic       rfsh_done;

  // Urgent refresh debt outranks the C64 port; a small debt only fills idle slots.
  always_comb begin
    winner = GNT_NONE;
    if (int'(debt_q) >= URGENT_DEBT) winner = GNT_RFSH;
    else if (c64_req)                winner = GNT_C64;
    else if (io_req)                 winner = GNT_IO;
    else if (debt_q != 2'd0)         winner = GNT_RFSH;
  end

  assign wrap      = (cnt_q == CNT_LAST);
  assign rfsh_done = (state_q == ST_BUSY) && (grant_q == GNT_RFSH) && mem_done;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap ? '0 : cnt_q + CNT_W'(1);
    debt_d      = debt_q;
    grant_d     = grant_q;
    mem_start_d = 1'b0;
    mem_rfsh_d  = mem_rfsh_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    c64_dout_d  = c64_dout_q;
    io_dout_d   = io_dout_q;
    c64_ack_d   = 1'b0;
    io_ack_d    = 1'b0;

    // A wrap and a completed refresh in the same cycle cancel out.
    if (wrap && !rfsh_done && debt_q != 2'd3)        debt_d = debt_q + 2'd1;
    else if (!wrap && rfsh_done && debt_q != 2'd0)   debt_d = debt_q - 2'd1;

    case (state_q)
      ST_IDLE: begin
        if (winner != GNT_NONE) begin
          mem_start_d = 1'b1;
          grant_d     = winner;
          state_d     = ST_BUSY;
          case (winner)
            GNT_C64: begin
              mem_rfsh_d = 1'b0;
              mem_we_d   = c64_we;
              mem_addr_d = c64_addr;
              mem_din_d  = c64_din;
            end
            GNT_IO: begin
              mem_rfsh_d = 1'b0;
              mem_we_d   = io_we;
              mem_addr_d = io_addr;
              mem_din_d  = io_din;
            end
            default: begin
              mem_rfsh_d = 1'b1;
              mem_we_d   = 1'b0;
            end
          endcase
        end
      end
      ST_BUSY: begin
        if (mem_done) begin
          grant_d = GNT_NONE;
          state_d = (grant_q == GNT_RFSH) ? ST_IDLE : ST_ACK;
          if (grant_q == GNT_C64) begin
            c64_ack_d = 1'b1;
            if (!mem_we_q) c64_dout_d = mem_dout;
          end
          if (grant_q == GNT_IO) begin
            io_ack_d = 1'b1;
            if (!mem_we_q) io_dout_d = mem_dout;
          end
        end
      end
      // The ack cycle gives the requester time to drop its request.
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_c64) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      debt_q      <= 2'd0;
      grant_q     <= GNT_NONE;
      mem_start_q <= 1'b0;
      mem_rfsh_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= 8'h00;
      c64_dout_q  <= 8'h00;
      io_dout_q   <= 8'h00;
      c64_ack_q   <= 1'b0;
      io_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      debt_q      <= debt_d;
      grant_q     <= grant_d;
      mem_start_q <= mem_start_d;
      mem_rfsh_q  <= mem_rfsh_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      c64_dout_q  <= c64_dout_d;
      io_dout_q   <= io_dout_d;
      c64_ack_q   <= c64_ack_d;
      io_ack_q    <= io_ack_d;
    end
  end

  assign mem_start = mem_start_q;
  assign mem_rfsh  = mem_rfsh_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign c64_dout  = c64_dout_q;
  assign io_dout   = io_dout_q;
  assign c64_ack   = c64_ack_q;
  assign io_ack    = io_ack_q;
  assign grant     = grant_q;
  assign rfsh_debt = debt_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: SDRAM responder model, command/ack scoreboards,
// a table of single accesses and hand-written refresh/collision/reset sequences.
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25;
  localparam int NV     = 9;

  logic              clk_c64, reset_n;
  logic              c64_req, c64_we, c64_ack;
  logic [ADDR_W-1:0] c64_addr;
  logic [7:0]        c64_din, c64_dout;
  logic              io_req, io_we, io_ack;
  logic [ADDR_W-1:0] io_addr;
  logic [7:0]        io_din, io_dout;
  logic              mem_start, mem_rfsh, mem_we, mem_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din, mem_dout;
  logic [1:0]        grant, rfsh_debt;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .REFRESH_CYCLES(250), .URGENT_DEBT(2)) dut (
    .clk_c64(clk_c64), .reset_n(reset_n),
    .c64_req(c64_req), .c64_we(c64_we), .c64_addr(c64_addr), .c64_din(c64_din),
    .c64_dout(c64_dout), .c64_ack(c64_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_din(io_din),
    .io_dout(io_dout), .io_ack(io_ack),
    .mem_start(mem_start), .mem_rfsh(mem_rfsh), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_done(mem_done),
    .grant(grant), .rfsh_debt(rfsh_debt)
  );

  typedef struct {
    logic              rfsh;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
  } cmd_t;

  typedef struct {
    bit                io;
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    logic [7:0]        rd_exp;
    int                lat;
  } vec_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_c64_q[$];
  logic [7:0] exp_io_q[$];
  logic [7:0] sdram [bit [ADDR_W-1:0]];
  vec_t       vecs [NV];

  int         total = 0;
  int         bad = 0;
  int         ec = 0;
  int         rsp_lat = 3;
  int         spur_req = 0;
  logic [7:0] last_c64 = 8'h00;
  logic [7:0] last_io = 8'h00;

  initial begin
    clk_c64 = 1'b0;
    forever #5 clk_c64 = ~clk_c64;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, ec);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk_c64);
      #1;
      ec++;
    end
  endtask

  task automatic goto_edge(input int k);
    while (ec < k) wait_edges(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    c64_req = 1'b0;
    io_req  = 1'b0;
    repeat (3) @(posedge clk_c64);
    #1 reset_n = 1'b1;
    ec       = 0;
    last_c64 = 8'h00;
    last_io  = 8'h00;
  endtask

  task automatic wait_ack(input bit io, input int limit, output int n);
    bit got;
    got = 1'b0;
    n   = 0;
    while (!got && n < limit) begin
      wait_edges(1);
      n++;
      got = io ? io_ack : c64_ack;
    end
    check(io ? "io_ack_seen" : "c64_ack_seen", 32'(got), 32'd1);
  endtask

  task automatic push_cmd(input logic rfsh, input logic we, input logic [ADDR_W-1:0] a,
                          input logic [7:0] d);
    cmd_t c;
    c.rfsh = rfsh;
    c.we   = we;
    c.addr = a;
    c.din  = d;
    exp_cmd.push_back(c);
  endtask

  // One complete access starting from IDLE with no refresh debt outstanding.
  task automatic do_access(input vec_t v);
    int n;
    push_cmd(1'b0, v.we, v.addr, v.din);
    rsp_lat = v.lat;
    if (v.io) begin
      exp_io_q.push_back(v.we ? last_io : v.rd_exp);
      if (!v.we) last_io = v.rd_exp;
      io_we = v.we; io_addr = v.addr; io_din = v.din; io_req = 1'b1;
    end else begin
      exp_c64_q.push_back(v.we ? last_c64 : v.rd_exp);
      if (!v.we) last_c64 = v.rd_exp;
      c64_we = v.we; c64_addr = v.addr; c64_din = v.din; c64_req = 1'b1;
    end
    wait_edges(1);
    check("start_latency", 32'(mem_start), 32'd1);
    check("grant_owner", 32'(grant), v.io ? 32'd2 : 32'd1);
    wait_ack(v.io, 100, n);
    check("ack_latency", n, v.lat + 1);
    check("grant_after_ack", 32'(grant), 32'd0);
    c64_req = 1'b0;
    io_req  = 1'b0;
    wait_edges(1);
  endtask

  // SDRAM controller model: answers each mem_start after rsp_lat cycles.
  initial begin : responder
    int                cnt;
    bit                busy;
    bit                spur_done_i;
    int                spur_done;
    logic              rd;
    logic [ADDR_W-1:0] a;
    mem_done  = 1'b0;
    mem_dout  = 8'h00;
    busy      = 1'b0;
    cnt       = 0;
    spur_done = 0;
    rd        = 1'b0;
    a         = '0;
    spur_done_i = 1'b0;
    forever begin
      @(posedge clk_c64);
      #1;
      mem_done = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          busy     = 1'b0;
          mem_done = 1'b1;
          mem_dout = rd ? (sdram.exists(a) ? sdram[a] : 8'h00) : 8'($urandom);
        end
      end else if (spur_req != spur_done) begin
        spur_done++;
        spur_done_i = 1'b1;
        mem_done    = 1'b1;
        mem_dout    = 8'hEE;
      end
      if (mem_start) begin
        busy = 1'b1;
        cnt  = rsp_lat;
        rd   = !mem_we && !mem_rfsh;
        a    = mem_addr;
        if (mem_we && !mem_rfsh) sdram[mem_addr] = mem_din;
      end
    end
  end

  initial begin : cmd_mon
    cmd_t e;
    forever begin
      @(negedge clk_c64);
      if (mem_start) begin
        if (exp_cmd.size() == 0) begin
          check("cmd_expected", exp_cmd.size(), 32'd1);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_rfsh", 32'(mem_rfsh), 32'(e.rfsh));
          check("cmd_we", 32'(mem_we), 32'(e.we));
          if (!e.rfsh) check("cmd_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we && !e.rfsh) check("cmd_din", 32'(mem_din), 32'(e.din));
        end
      end
    end
  end

  initial begin : ack_mon
    logic [7:0] e;
    forever begin
      @(negedge clk_c64);
      if (c64_ack) begin
        if (exp_c64_q.size() == 0) check("c64_ack_expected", exp_c64_q.size(), 32'd1);
        else begin
          e = exp_c64_q.pop_front();
          check("c64_dout", 32'(c64_dout), 32'(e));
        end
      end
      if (io_ack) begin
        if (exp_io_q.size() == 0) check("io_ack_expected", exp_io_q.size(), 32'd1);
        else begin
          e = exp_io_q.pop_front();
          check("io_dout", 32'(io_dout), 32'(e));
        end
      end
    end
  end

  initial begin : main
    int n;
    c64_req = 1'b0; c64_we = 1'b0; c64_addr = '0; c64_din = 8'h00;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_din  = 8'h00;
    reset_n = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 25'h0001000, 8'h00, 8'hA5, 3};
    vecs[1] = '{1'b0, 1'b1, 25'h0000123, 8'h5A, 8'h00, 2};
    vecs[2] = '{1'b1, 1'b0, 25'h0000123, 8'h00, 8'h5A, 1};
    vecs[3] = '{1'b1, 1'b1, 25'h1FFFFFF, 8'hC3, 8'h00, 4};
    vecs[4] = '{1'b0, 1'b0, 25'h1FFFFFF, 8'h00, 8'hC3, 2};
    vecs[5] = '{1'b0, 1'b1, 25'h0000000, 8'hFF, 8'h00, 1};
    vecs[6] = '{1'b1, 1'b0, 25'h0000000, 8'h00, 8'hFF, 5};
    vecs[7] = '{1'b0, 1'b0, 25'h0ABCDEF, 8'h00, 8'h96, 3};
    vecs[8] = '{1'b1, 1'b1, 25'h0010000, 8'h3C, 8'h00, 2};

    // Reset state, idle refresh scheduling, wrap/completion coincidence, saturation.
    do_reset();
    check("rst_ctrl", {25'd0, mem_start, mem_rfsh, mem_we, c64_ack, io_ack, grant}, 32'd0);
    check("rst_debt", 32'(rfsh_debt), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_data", {8'd0, mem_din, c64_dout, io_dout}, 32'd0);
    goto_edge(100);
    spur_req++;
    goto_edge(249);
    check("idle249_ctrl", {25'd0, mem_start, mem_rfsh, mem_we, c64_ack, io_ack, grant}, 32'd0);
    check("idle249_debt", 32'(rfsh_debt), 32'd0);
    rsp_lat = 3;
    push_cmd(1'b1, 1'b0, '0, 8'h00);
    goto_edge(250);
    check("wrap_debt", 32'(rfsh_debt), 32'd1);
    check("wrap_no_start_yet", 32'(mem_start), 32'd0);
    goto_edge(251);
    check("rfsh_start", 32'(mem_start), 32'd1);
    check("rfsh_grant", 32'(grant), 32'd3);
    goto_edge(256);
    check("rfsh_done_debt", 32'(rfsh_debt), 32'd0);
    check("rfsh_done_grant", 32'(grant), 32'd0);
    rsp_lat = 248;
    push_cmd(1'b1, 1'b0, '0, 8'h00);
    goto_edge(501);
    check("rfsh2_start", 32'(mem_start), 32'd1);
    goto_edge(600);
    rsp_lat = 1000;
    push_cmd(1'b1, 1'b0, '0, 8'h00);
    goto_edge(749);
    check("pre_coincide_debt", 32'(rfsh_debt), 32'd1);
    goto_edge(750);
    check("coincide_debt", 32'(rfsh_debt), 32'd1);
    check("coincide_grant", 32'(grant), 32'd0);
    goto_edge(751);
    check("rfsh3_start", 32'(mem_start), 32'd1);
    goto_edge(1000);
    check("debt_2", 32'(rfsh_debt), 32'd2);
    goto_edge(1250);
    check("debt_3", 32'(rfsh_debt), 32'd3);
    goto_edge(1750);
    check("debt_saturated", 32'(rfsh_debt), 32'd3);
    goto_edge(1752);
    check("debt_after_sat_done", 32'(rfsh_debt), 32'd2);

    // Table of single accesses from both ports.
    do_reset();
    sdram[25'h0001000] = 8'hA5;
    sdram[25'h0ABCDEF] = 8'h96;
    for (int i = 0; i < NV; i++) do_access(vecs[i]);

    // Collision: C64 first, io held and served afterwards.
    do_reset();
    rsp_lat = 3;
    push_cmd(1'b0, 1'b0, 25'h0001000, 8'h00);
    push_cmd(1'b0, 1'b1, 25'h0010000, 8'h3C);
    exp_c64_q.push_back(8'hA5);
    exp_io_q.push_back(8'h00);
    c64_we = 1'b0; c64_addr = 25'h0001000; c64_din = 8'h00; c64_req = 1'b1;
    io_we  = 1'b1; io_addr  = 25'h0010000; io_din  = 8'h3C; io_req  = 1'b1;
    wait_edges(1);
    check("coll_grant_c64", 32'(grant), 32'd1);
    wait_ack(1'b0, 50, n);
    c64_req = 1'b0;
    check("coll_io_waiting", 32'(io_ack), 32'd0);
    wait_ack(1'b1, 50, n);
    io_req = 1'b0;
    wait_edges(1);
    do_access('{1'b1, 1'b0, 25'h0010000, 8'h00, 8'h3C, 2});

    // Urgent refresh overtakes a pending C64 request.
    do_reset();
    sdram[25'h0002000] = 8'h77;
    sdram[25'h0002001] = 8'h88;
    rsp_lat = 510;
    push_cmd(1'b0, 1'b0, 25'h0002000, 8'h00);
    exp_c64_q.push_back(8'h77);
    c64_we = 1'b0; c64_addr = 25'h0002000; c64_din = 8'h00; c64_req = 1'b1;
    goto_edge(1);
    check("urg_c64_start", 32'(mem_start), 32'd1);
    goto_edge(5);
    rsp_lat = 3;
    wait_ack(1'b0, 600, n);
    check("urg_debt_at_ack", 32'(rfsh_debt), 32'd2);
    push_cmd(1'b1, 1'b0, '0, 8'h00);
    push_cmd(1'b0, 1'b0, 25'h0002001, 8'h00);
    push_cmd(1'b1, 1'b0, '0, 8'h00);
    exp_c64_q.push_back(8'h88);
    c64_addr = 25'h0002001;
    wait_edges(2);
    check("urg_rfsh_first", 32'(mem_start), 32'd1);
    check("urg_rfsh_grant", 32'(grant), 32'd3);
    wait_ack(1'b0, 50, n);
    c64_req = 1'b0;
    check("urg_debt_after_c64", 32'(rfsh_debt), 32'd1);
    wait_edges(10);
    check("urg_debt_cleared", 32'(rfsh_debt), 32'd0);
    check("urg_grant_idle", 32'(grant), 32'd0);

    // Reset during BUSY; mem_done lands while reset is held.
    do_reset();
    rsp_lat = 4;
    push_cmd(1'b0, 1'b0, 25'h0001000, 8'h00);
    c64_we = 1'b0; c64_addr = 25'h0001000; c64_din = 8'h00; c64_req = 1'b1;
    goto_edge(1);
    check("mid_start", 32'(mem_start), 32'd1);
    goto_edge(3);
    check("mid_busy_grant", 32'(grant), 32'd1);
    do_reset();
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_ack", {30'd0, c64_ack, mem_start}, 32'd0);
    check("mid_rst_dout", 32'(c64_dout), 32'd0);
    spur_req++;
    wait_edges(3);
    check("spur_grant", 32'(grant), 32'd0);
    check("spur_debt", 32'(rfsh_debt), 32'd0);
    do_access('{1'b0, 1'b0, 25'h0001000, 8'h00, 8'hA5, 1});

    // Requester inputs changing during BUSY do not reach the command.
    do_reset();
    rsp_lat = 5;
    push_cmd(1'b0, 1'b1, 25'h0000040, 8'h11);
    exp_c64_q.push_back(8'h00);
    c64_we = 1'b1; c64_addr = 25'h0000040; c64_din = 8'h11; c64_req = 1'b1;
    goto_edge(1);
    check("ign_start", 32'(mem_start), 32'd1);
    c64_addr = 25'h1FFFFFF; c64_din = 8'hFF; c64_we = 1'b0;
    goto_edge(3);
    check("ign_addr", 32'(mem_addr), 32'h40);
    check("ign_we_din", {23'd0, mem_rfsh, mem_we, mem_din}, {23'd0, 1'b0, 1'b1, 8'h11});
    wait_ack(1'b0, 50, n);
    c64_req = 1'b0;
    wait_edges(1);
    do_access('{1'b1, 1'b0, 25'h0000040, 8'h00, 8'h11, 2});

    wait_edges(5);
    check("cmd_queue_left", exp_cmd.size(), 32'd0);
    check("c64_queue_left", exp_c64_q.size(), 32'd0);
    check("io_queue_left", exp_io_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
